// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master FIFO engine.
// The engine drives SPI mode 0 (CPOL=0, CPHA=0), MSB first.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    DONE,
    GAP,
    TRAIL
  } spi_state_t;

  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

  // Number of pclk cycles spent in SHIFT for one frame.
  function automatic int frame_cycles(input int frame_bits, input int clk_div);
    return 2 * frame_bits * clk_div;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: half-period counter that toggles sclk every CLK_DIV cycles
// while enabled and reports which toggle is happening on this cycle.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic pclk,
  input  logic preset,
  input  logic en,
  input  logic clr,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic          sclk_reg;
  logic          wrap;

  assign wrap = en && (cnt_reg == CNT_LAST);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt_reg  <= '0;
      sclk_reg <= CPOL;
    end else if (clr) begin
      cnt_reg  <= '0;
      sclk_reg <= CPOL;
    end else if (en) begin
      if (wrap) begin
        cnt_reg  <= '0;
        sclk_reg <= ~sclk_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // Ticks flag the cycle whose closing edge performs the toggle.
  assign rise_tick = wrap && !sclk_reg;
  assign fall_tick = wrap && sclk_reg;
  assign sclk      = sclk_reg;

endmodule

// File: rtl/spi_master_fifo_engine.sv
// SPI master that drains the bridge TX FIFO into SPI frames and pushes the
// captured MISO frames into the RX FIFO, holding cs_n low across bursts.
module spi_master_fifo_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_BITS = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  output logic                  read_fifo_tx,
  input  logic                  empty_tx,
  input  logic [DATA_WIDTH-1:0] fifo_r_data_tx,
  output logic                  write_fifo_rx,
  input  logic                  full_rx,
  output logic [DATA_WIDTH-1:0] fifo_w_data_rx,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  busy
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

  spi_state_t state_reg, state_next;

  logic [FRAME_BITS-1:0] tx_sh_reg;
  logic [FRAME_BITS-1:0] rx_sh_reg;
  logic [BW-1:0]         bit_cnt_reg;
  logic [HW-1:0]         hold_cnt_reg;
  logic                  cs_n_reg;

  logic start_ok;
  logic hold_active;
  logic hold_done;
  logic last_bit;
  logic div_en;
  logic rise_tick;
  logic fall_tick;
  logic sample_tick;
  logic shift_tick;

  assign start_ok    = !empty_tx && !full_rx;
  assign hold_active = (state_reg == LEAD) || (state_reg == TRAIL);
  assign hold_done   = hold_active && (hold_cnt_reg == HOLD_LAST);
  assign last_bit    = (bit_cnt_reg == BIT_LAST);
  assign div_en      = (state_reg == SHIFT);

  // Mode 0: capture on the leading (rising) edge, shift on the trailing one.
  assign sample_tick = (CPHA == 1'b0) ? rise_tick : fall_tick;
  assign shift_tick  = (CPHA == 1'b0) ? fall_tick : rise_tick;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .pclk      (pclk),
    .preset    (preset),
    .en        (div_en),
    .clr       (!div_en),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sclk      (sclk)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    read_fifo_tx  = 1'b0;
    write_fifo_rx = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          read_fifo_tx = 1'b1;
          state_next   = LEAD;
        end
      end
      LEAD: begin
        if (hold_done) state_next = SHIFT;
      end
      SHIFT: begin
        if (shift_tick && last_bit) state_next = DONE;
      end
      DONE: begin
        write_fifo_rx = 1'b1;
        state_next    = GAP;
      end
      GAP: begin
        // full_rx is one cycle past the push here, so its status is current.
        if (start_ok) begin
          read_fifo_tx = 1'b1;
          state_next   = LEAD;
        end else begin
          state_next = TRAIL;
        end
      end
      TRAIL: begin
        if (hold_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tx_sh_reg    <= '0;
      rx_sh_reg    <= '0;
      bit_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      cs_n_reg     <= 1'b1;
    end else begin
      if (read_fifo_tx) begin
        tx_sh_reg   <= fifo_r_data_tx[FRAME_BITS-1:0];
        rx_sh_reg   <= '0;
        bit_cnt_reg <= '0;
        cs_n_reg    <= 1'b0;
      end else begin
        if (sample_tick) rx_sh_reg <= (rx_sh_reg << 1) | FRAME_BITS'(miso);
        if (shift_tick) begin
          tx_sh_reg   <= tx_sh_reg << 1;
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
        if ((state_reg == TRAIL) && hold_done) cs_n_reg <= 1'b1;
      end
      hold_cnt_reg <= (hold_active && !hold_done) ? hold_cnt_reg + 1'b1 : '0;
    end
  end

  // Bits above the frame are never transmitted.
  generate
    if (FRAME_BITS < DATA_WIDTH) begin : g_hi_unused
      logic unused_hi;
      assign unused_hi = ^fifo_r_data_tx[DATA_WIDTH-1:FRAME_BITS];
    end
  endgenerate

  // tx_sh fills with zeros as it shifts, so mosi idles low after each frame.
  assign mosi           = tx_sh_reg[FRAME_BITS-1];
  assign cs_n           = cs_n_reg;
  assign busy           = (state_reg != IDLE);
  assign fifo_w_data_rx = write_fifo_rx ? DATA_WIDTH'(rx_sh_reg) : '0;

endmodule

// File: tb/tb_spi_master_fifo_engine.sv
// Self-checking bench: three engines (8b/div2, 32b/div1, 8b/div5) against
// a queue-based FIFO/slave model evaluated once per pclk at the falling edge.
module tb_spi_master_fifo_engine;

  localparam int FB [3] = '{8, 32, 8};
  localparam int DV [3] = '{2, 1, 5};

  logic        pclk;
  logic        preset;
  logic        rd      [3];
  logic        empty_tx[3];
  logic [31:0] head    [3];
  logic        wr      [3];
  logic        full_rx [3];
  logic [31:0] wdata   [3];
  logic        sclk    [3];
  logic        mosi    [3];
  logic        miso    [3];
  logic        cs_n    [3];
  logic        busy    [3];

  spi_master_fifo_engine #(.DATA_WIDTH(32), .FRAME_BITS(8), .CLK_DIV(2)) u0 (
    .pclk(pclk), .preset(preset), .read_fifo_tx(rd[0]), .empty_tx(empty_tx[0]),
    .fifo_r_data_tx(head[0]), .write_fifo_rx(wr[0]), .full_rx(full_rx[0]),
    .fifo_w_data_rx(wdata[0]), .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso[0]),
    .cs_n(cs_n[0]), .busy(busy[0]));
  spi_master_fifo_engine #(.DATA_WIDTH(32), .FRAME_BITS(32), .CLK_DIV(1)) u1 (
    .pclk(pclk), .preset(preset), .read_fifo_tx(rd[1]), .empty_tx(empty_tx[1]),
    .fifo_r_data_tx(head[1]), .write_fifo_rx(wr[1]), .full_rx(full_rx[1]),
    .fifo_w_data_rx(wdata[1]), .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso[1]),
    .cs_n(cs_n[1]), .busy(busy[1]));
  spi_master_fifo_engine #(.DATA_WIDTH(32), .FRAME_BITS(8), .CLK_DIV(5)) u2 (
    .pclk(pclk), .preset(preset), .read_fifo_tx(rd[2]), .empty_tx(empty_tx[2]),
    .fifo_r_data_tx(head[2]), .write_fifo_rx(wr[2]), .full_rx(full_rx[2]),
    .fifo_w_data_rx(wdata[2]), .sclk(sclk[2]), .mosi(mosi[2]), .miso(miso[2]),
    .cs_n(cs_n[2]), .busy(busy[2]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  // Model state: TX FIFO contents, expected RX/MOSI frames, slave config.
  logic [31:0] tx_mem  [3][16];
  logic [31:0] exp_rx  [3][16];
  logic [31:0] exp_tx  [3][16];
  int          tx_wr[3], tx_rd[3], ex_wr[3], ex_rd[3];
  logic        full_v  [3];
  logic        loop_m  [3];
  logic [31:0] pattern [3];

  // Monitor state.
  int          pops[3], pushes[3], rises[3], sessions[3], cs_cnt[3], last_cs_len[3];
  int          hi_len[3], hi_min[3], hi_max[3], lo_run[3], lo_max[3], write_at[3];
  int          fall_idx[3];
  logic        prev_sclk[3], prev_cs[3];
  logic [63:0] mosi_acc[3];
  logic [31:0] last_rx[3], last_mosi[3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mask_of(input int f);
    logic [63:0] m;
    m = (64'd1 << f) - 64'd1;
    return m[31:0];
  endfunction

  task automatic push_tx(input int i, input logic [31:0] w);
    tx_mem[i][tx_wr[i] % 16] = w;
    tx_wr[i]++;
  endtask

  task automatic clear_mon(input int i);
    pops[i] = 0; pushes[i] = 0; rises[i] = 0; sessions[i] = 0; cs_cnt[i] = 0;
    last_cs_len[i] = 0; hi_len[i] = 0; hi_min[i] = 1000; hi_max[i] = 0;
    lo_run[i] = 0; lo_max[i] = 0; write_at[i] = 0; mosi_acc[i] = '0;
  endtask

  // One pclk: drive inputs at the falling edge, observe settled outputs 1 ns later.
  task automatic cycle();
    logic [31:0] w;
    @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      if (cs_n[i]) fall_idx[i] = 0;
      else if (prev_sclk[i] && !sclk[i]) fall_idx[i] = (fall_idx[i] + 1) % FB[i];
      empty_tx[i] = (tx_wr[i] == tx_rd[i]);
      head[i]     = empty_tx[i] ? 32'h0 : tx_mem[i][tx_rd[i] % 16];
      full_rx[i]  = full_v[i];
      miso[i]     = loop_m[i] ? mosi[i] : pattern[i][FB[i] - 1 - fall_idx[i]];
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy_vs_csn%0d", i), {63'd0, busy[i]}, {63'd0, !cs_n[i]});
      if (rd[i]) begin
        pops[i]++;
        w = (tx_wr[i] != tx_rd[i]) ? tx_mem[i][tx_rd[i] % 16] : 32'h0;
        if (tx_wr[i] != tx_rd[i]) tx_rd[i]++;
        exp_rx[i][ex_wr[i] % 16] = (loop_m[i] ? w : pattern[i]) & mask_of(FB[i]);
        exp_tx[i][ex_wr[i] % 16] = w & mask_of(FB[i]);
        ex_wr[i]++;
      end
      if (wr[i]) begin
        pushes[i]++;
        write_at[i]  = cs_cnt[i];
        last_rx[i]   = wdata[i];
        last_mosi[i] = mosi_acc[i][31:0];
        if (ex_wr[i] == ex_rd[i]) begin
          check($sformatf("rx_unexpected%0d", i), 64'd1, 64'd0);
        end else begin
          check($sformatf("rx_data%0d", i), {32'd0, wdata[i]}, {32'd0, exp_rx[i][ex_rd[i] % 16]});
          check($sformatf("mosi_bits%0d", i), mosi_acc[i], {32'd0, exp_tx[i][ex_rd[i] % 16]});
          ex_rd[i]++;
        end
        mosi_acc[i] = '0;
      end
      if (sclk[i] && !prev_sclk[i]) begin
        rises[i]++;
        mosi_acc[i] = (mosi_acc[i] << 1) | {63'd0, mosi[i]};
      end
      if (sclk[i]) hi_len[i]++;
      else if (prev_sclk[i]) begin
        if (hi_len[i] < hi_min[i]) hi_min[i] = hi_len[i];
        if (hi_len[i] > hi_max[i]) hi_max[i] = hi_len[i];
        hi_len[i] = 0;
      end
      if (!cs_n[i]) begin
        cs_cnt[i]++;
        if (!sclk[i]) lo_run[i]++;
        else begin
          if (lo_run[i] > lo_max[i]) lo_max[i] = lo_run[i];
          lo_run[i] = 0;
        end
      end else begin
        if (!prev_cs[i]) begin
          sessions[i]++;
          last_cs_len[i] = cs_cnt[i];
        end
        cs_cnt[i] = 0;
        lo_run[i] = 0;
      end
      prev_sclk[i] = sclk[i];
      prev_cs[i]   = cs_n[i];
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_rises(input int i, input int n, input int budget);
    for (int k = 0; k < budget && rises[i] < n; k++) cycle();
    check("rise_timeout", {63'd0, rises[i] >= n}, 64'd1);
  endtask

  initial begin
    logic [31:0] w0, w1;
    preset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      empty_tx[i] = 1'b1; head[i] = '0; full_rx[i] = 1'b0; miso[i] = 1'b0;
      full_v[i] = 1'b0; loop_m[i] = 1'b1; pattern[i] = '0;
      tx_wr[i] = 0; tx_rd[i] = 0; ex_wr[i] = 0; ex_rd[i] = 0; fall_idx[i] = 0;
      prev_sclk[i] = 1'b0; prev_cs[i] = 1'b1; last_rx[i] = '0; last_mosi[i] = '0;
      clear_mon(i);
    end
    repeat (2) @(negedge pclk);
    #1;
    check("rst_cs_n", {63'd0, cs_n[0]}, 64'd1);
    check("rst_sclk", {63'd0, sclk[0]}, 64'd0);
    check("rst_mosi", {63'd0, mosi[0]}, 64'd0);
    check("rst_busy", {63'd0, busy[0]}, 64'd0);
    check("rst_rd",   {63'd0, rd[0]},   64'd0);
    check("rst_wr",   {63'd0, wr[0]},   64'd0);
    check("rst_wdata", {32'd0, wdata[0]}, 64'd0);
    preset = 1'b0;
    run(4);

    // Single frame, slave returns 0x3C.
    loop_m[0] = 1'b0; pattern[0] = 32'h3C; clear_mon(0);
    push_tx(0, 32'h0000_00A5);
    run(60);
    check("t1_pops", pops[0], 1);
    check("t1_pushes", pushes[0], 1);
    check("t1_rx", {32'd0, last_rx[0]}, 64'h3C);
    check("t1_mosi", {32'd0, last_mosi[0]}, 64'hA5);
    check("t1_rises", rises[0], 8);
    check("t1_hi_min", hi_min[0], DV[0]);
    check("t1_hi_max", hi_max[0], DV[0]);
    check("t1_cs_len", last_cs_len[0], 2 + 32 + 1 + 1 + 2);

    // Back-to-back loopback frames under one chip select.
    loop_m[0] = 1'b1; clear_mon(0);
    push_tx(0, 32'h11); push_tx(0, 32'h22); push_tx(0, 32'h33);
    run(150);
    check("t2_pops", pops[0], 3);
    check("t2_pushes", pushes[0], 3);
    check("t2_sessions", sessions[0], 1);
    check("t2_cs_len", last_cs_len[0], 3 * (DV[0] + 2 * 8 * DV[0] + 2) + DV[0]);
    check("t2_gap_low", lo_max[0], 2 + 2 * DV[0]);
    check("t2_last_rx", {32'd0, last_rx[0]}, 64'h33);

    // RX full blocks the start; release starts on the next cycle.
    loop_m[0] = 1'b0; pattern[0] = $urandom; full_v[0] = 1'b1; clear_mon(0);
    push_tx(0, $urandom);
    run(20);
    check("t3_no_pop", pops[0], 0);
    check("t3_cs_n", {63'd0, cs_n[0]}, 64'd1);
    check("t3_busy", {63'd0, busy[0]}, 64'd0);
    full_v[0] = 1'b0;
    cycle();
    check("t3_start", pops[0], 1);
    run(60);
    check("t3_pushes", pushes[0], 1);

    // RX fills during frame 1 of 2.
    loop_m[0] = 1'b1; clear_mon(0);
    push_tx(0, $urandom); push_tx(0, $urandom);
    wait_rises(0, 4, 60);
    full_v[0] = 1'b1;
    run(60);
    check("t4_pops", pops[0], 1);
    check("t4_pushes", pushes[0], 1);
    check("t4_sessions", sessions[0], 1);
    check("t4_cs_len", last_cs_len[0], 2 + 32 + 1 + 1 + 2);
    run(20);
    check("t4_held", pops[0], 1);
    check("t4_cs_high", {63'd0, cs_n[0]}, 64'd1);
    full_v[0] = 1'b0;
    run(60);
    check("t4_pops2", pops[0], 2);
    check("t4_pushes2", pushes[0], 2);

    // Reset in the middle of a frame.
    loop_m[0] = 1'b0; pattern[0] = $urandom; clear_mon(0);
    push_tx(0, $urandom);
    wait_rises(0, 4, 60);
    preset = 1'b1;
    #1;
    check("t5_cs_n", {63'd0, cs_n[0]}, 64'd1);
    check("t5_sclk", {63'd0, sclk[0]}, 64'd0);
    check("t5_mosi", {63'd0, mosi[0]}, 64'd0);
    check("t5_busy", {63'd0, busy[0]}, 64'd0);
    run(3);
    preset = 1'b0;
    check("t5_no_push", pushes[0], 0);
    ex_rd[0] = ex_wr[0];
    clear_mon(0);
    run(10);
    check("t5_idle_pops", pops[0], 0);
    check("t5_idle_cs", {63'd0, cs_n[0]}, 64'd1);
    push_tx(0, $urandom);
    run(60);
    check("t5_resume", pushes[0], 1);

    // Parameter sweep: full-width div1 and narrow div5.
    w0 = $urandom;
    w1 = $urandom | 32'hFFFF_0000;
    clear_mon(1); clear_mon(2);
    push_tx(1, w0); push_tx(1, 32'hDEAD_BEEF);
    push_tx(2, w1);
    run(180);
    check("t6a_pushes", pushes[1], 2);
    check("t6a_rises", rises[1], 64);
    check("t6a_hi_min", hi_min[1], 1);
    check("t6a_hi_max", hi_max[1], 1);
    check("t6a_cs_len", last_cs_len[1], 2 * (1 + 64 + 2) + 1);
    check("t6a_rx", {32'd0, last_rx[1]}, 64'hDEAD_BEEF);
    check("t6b_pushes", pushes[2], 1);
    check("t6b_shift", write_at[2] - DV[2], 80);
    check("t6b_hi_max", hi_max[2], 5);
    check("t6b_cs_len", last_cs_len[2], 5 + 80 + 2 + 5);
    check("t6b_rx_zext", {32'd0, last_rx[2]}, {56'd0, w1[7:0]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
